// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared LC2K register-file constants, index/word types and FSM states.
package lc2k_pkg;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef enum logic [0:0] {RF_INIT = 1'b0, RF_RUN = 1'b1} rf_state_t;
endpackage

// File: rtl/lc2k_regfile_wb_if.sv
// lc2k_regfile_wb_if: write-back, issue and operand-read signals of the LC2K register file.
interface lc2k_regfile_wb_if;
    import lc2k_pkg::*;
    logic wb_valid;
    logic wb_ready;
    reg_idx_t wb_dest;
    word_t wb_data;
    logic issue_valid;
    reg_idx_t issue_dest;
    logic rd_en;
    reg_idx_t rd_addr_a;
    reg_idx_t rd_addr_b;
    logic rd_stall;
    logic rd_valid;
    word_t rd_data_a;
    word_t rd_data_b;
    logic [NUM_REGS-1:0] busy;
    modport master (
        output wb_valid, wb_dest, wb_data, issue_valid, issue_dest, rd_en, rd_addr_a, rd_addr_b,
        input wb_ready, rd_stall, rd_valid, rd_data_a, rd_data_b, busy
    );
    modport slave (
        input wb_valid, wb_dest, wb_data, issue_valid, issue_dest, rd_en, rd_addr_a, rd_addr_b,
        output wb_ready, rd_stall, rd_valid, rd_data_a, rd_data_b, busy
    );
endinterface

// File: rtl/lc2k_scoreboard.sv
// lc2k_scoreboard: per-register busy bits; an issue outranks a same-cycle write-back clear.
module lc2k_scoreboard
    import lc2k_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic set_en,
    input  reg_idx_t set_idx,
    input  logic clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t addr_a,
    input  reg_idx_t addr_b,
    output logic [NUM_REGS-1:0] busy,
    output logic busy_a,
    output logic busy_b
);
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    assign set_vec = (set_en && set_idx != '0) ? NUM_REGS'(1) << set_idx : '0;
    assign clr_vec = clr_en ? NUM_REGS'(1) << clr_idx : '0;
    // A write-back landing this cycle already satisfies a waiting reader.
    assign busy_a = busy[addr_a] & (addr_a != '0) & ~clr_vec[addr_a];
    assign busy_b = busy[addr_b] & (addr_b != '0) & ~clr_vec[addr_b];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else busy <= set_vec | (busy & ~clr_vec);
    end
endmodule

// File: rtl/lc2k_regfile_wb.sv
// lc2k_regfile_wb: LC2K register file with post-reset clear sweep, write bypass and busy scoreboard.
module lc2k_regfile_wb
    import lc2k_pkg::*;
(
    input logic clk,
    input logic rst,
    lc2k_regfile_wb_if.slave bus
);
    rf_state_t state;
    reg_idx_t cnt;
    word_t regs [NUM_REGS];
    logic run;
    logic wb_acc;
    logic rd_fire;
    logic busy_a;
    logic busy_b;
    assign run = state == RF_RUN;
    assign bus.wb_ready = run;
    assign wb_acc = bus.wb_valid & run;
    assign bus.rd_stall = bus.rd_en & (~run | busy_a | busy_b);
    assign rd_fire = bus.rd_en & ~bus.rd_stall;
    lc2k_scoreboard u_sb (
        .clk(clk),
        .rst(rst),
        .set_en(bus.issue_valid & run),
        .set_idx(bus.issue_dest),
        .clr_en(wb_acc),
        .clr_idx(bus.wb_dest),
        .addr_a(bus.rd_addr_a),
        .addr_b(bus.rd_addr_b),
        .busy(bus.busy),
        .busy_a(busy_a),
        .busy_b(busy_b)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RF_INIT;
            cnt <= '0;
        end else if (!run) begin
            cnt <= cnt + reg_idx_t'(1);
            if (cnt == reg_idx_t'(NUM_REGS - 1)) state <= RF_RUN;
        end
    end
    // No reset on the array itself: the INIT sweep zeroes it before any read is allowed.
    always_ff @(posedge clk) begin
        if (!run) regs[cnt] <= '0;
        else if (wb_acc && bus.wb_dest != '0) regs[bus.wb_dest] <= bus.wb_data;
    end
    function automatic word_t rd_val(input reg_idx_t a);
        return (a == '0) ? '0 : (wb_acc && bus.wb_dest == a) ? bus.wb_data : regs[a];
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data_a <= '0;
            bus.rd_data_b <= '0;
        end else begin
            bus.rd_valid <= rd_fire;
            if (rd_fire) begin
                bus.rd_data_a <= rd_val(bus.rd_addr_a);
                bus.rd_data_b <= rd_val(bus.rd_addr_b);
            end
        end
    end
endmodule

// File: tb/tb_lc2k_regfile_wb.sv
// tb_lc2k_regfile_wb: directed self-checking bench for the LC2K write-back register file.
module tb_lc2k_regfile_wb;
    import lc2k_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    lc2k_regfile_wb_if bus();
    lc2k_regfile_wb dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        bus.wb_valid = 1'b0;
        bus.wb_dest = '0;
        bus.wb_data = '0;
        bus.issue_valid = 1'b0;
        bus.issue_dest = '0;
        bus.rd_en = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            chk({tag, "_ready_low"}, {31'd0, bus.wb_ready}, 32'd0);
            tick();
        end
        chk({tag, "_ready_high"}, {31'd0, bus.wb_ready}, 32'd1);
    endtask

    initial begin
        idle();
        tick();
        tick();
        chk("rst_ready", {31'd0, bus.wb_ready}, 32'd0);
        chk("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_busy", {24'd0, bus.busy}, 32'd0);
        chk("rst_data_a", bus.rd_data_a, 32'd0);
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd1;
        #1;
        chk("init_stall", {31'd0, bus.rd_stall}, 32'd1);
        bus.rd_en = 1'b0;
        rst = 1'b0;
        sweep("sweep1");
        // read regs 1 and 7 after the sweep
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd1;
        bus.rd_addr_b = 3'd7;
        #1;
        chk("rd17_stall", {31'd0, bus.rd_stall}, 32'd0);
        tick();
        idle();
        chk("rd17_valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("rd17_a", bus.rd_data_a, 32'd0);
        chk("rd17_b", bus.rd_data_b, 32'd0);
        tick();
        chk("idle_valid", {31'd0, bus.rd_valid}, 32'd0);
        // write then read
        bus.wb_valid = 1'b1;
        bus.wb_dest = 3'd3;
        bus.wb_data = 32'h0000_1234;
        tick();
        idle();
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd3;
        bus.rd_addr_b = 3'd0;
        tick();
        idle();
        chk("wr3_valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("wr3_a", bus.rd_data_a, 32'h0000_1234);
        chk("wr3_b", bus.rd_data_b, 32'd0);
        // bypass
        bus.wb_valid = 1'b1;
        bus.wb_dest = 3'd5;
        bus.wb_data = 32'hDEAD_BEEF;
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd5;
        bus.rd_addr_b = 3'd3;
        #1;
        chk("byp_stall", {31'd0, bus.rd_stall}, 32'd0);
        tick();
        idle();
        chk("byp_a", bus.rd_data_a, 32'hDEAD_BEEF);
        chk("byp_b", bus.rd_data_b, 32'h0000_1234);
        // scoreboard stall
        bus.issue_valid = 1'b1;
        bus.issue_dest = 3'd2;
        tick();
        idle();
        chk("iss2_busy", {24'd0, bus.busy}, 32'h04);
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd0;
        bus.rd_addr_b = 3'd2;
        #1;
        chk("iss2_stall_b", {31'd0, bus.rd_stall}, 32'd1);
        bus.rd_addr_a = 3'd2;
        bus.rd_addr_b = 3'd0;
        #1;
        chk("iss2_stall_a", {31'd0, bus.rd_stall}, 32'd1);
        tick();
        idle();
        chk("iss2_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("iss2_hold", bus.rd_data_a, 32'hDEAD_BEEF);
        // write-back releases the waiting reader in the same cycle
        bus.wb_valid = 1'b1;
        bus.wb_dest = 3'd2;
        bus.wb_data = 32'd7;
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd2;
        #1;
        chk("wb2_stall", {31'd0, bus.rd_stall}, 32'd0);
        tick();
        idle();
        chk("wb2_valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("wb2_a", bus.rd_data_a, 32'd7);
        chk("wb2_busy", {24'd0, bus.busy}, 32'd0);
        // issue and write-back on reg 4 together
        bus.issue_valid = 1'b1;
        bus.issue_dest = 3'd4;
        bus.wb_valid = 1'b1;
        bus.wb_dest = 3'd4;
        bus.wb_data = 32'd9;
        tick();
        idle();
        chk("iw4_busy", {24'd0, bus.busy}, 32'h10);
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd4;
        #1;
        chk("iw4_stall", {31'd0, bus.rd_stall}, 32'd1);
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_dest = 3'd4;
        bus.wb_data = 32'd10;
        tick();
        idle();
        chk("wb4_busy", {24'd0, bus.busy}, 32'd0);
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd4;
        bus.rd_addr_b = 3'd4;
        tick();
        idle();
        chk("rd4_a", bus.rd_data_a, 32'd10);
        chk("rd4_b", bus.rd_data_b, 32'd10);
        // reg0 stays zero and never goes busy
        bus.wb_valid = 1'b1;
        bus.wb_dest = 3'd0;
        bus.wb_data = 32'hFFFF_FFFF;
        tick();
        idle();
        bus.rd_en = 1'b1;
        tick();
        idle();
        chk("r0_valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("r0_a", bus.rd_data_a, 32'd0);
        chk("r0_b", bus.rd_data_b, 32'd0);
        bus.issue_valid = 1'b1;
        bus.issue_dest = 3'd0;
        tick();
        idle();
        chk("iss0_busy", {24'd0, bus.busy}, 32'd0);
        // reset while a read is in flight
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd3;
        bus.issue_valid = 1'b1;
        bus.issue_dest = 3'd6;
        tick();
        idle();
        chk("pre_rst_valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("pre_rst_busy", {24'd0, bus.busy}, 32'h40);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("mid_rst_data", bus.rd_data_a, 32'd0);
        chk("mid_rst_busy", {24'd0, bus.busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.wb_ready}, 32'd0);
        tick();
        rst = 1'b0;
        sweep("sweep2");
        // reset partway through a sweep restarts it from 0
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep("sweep3");
        bus.rd_en = 1'b1;
        bus.rd_addr_a = 3'd3;
        bus.rd_addr_b = 3'd4;
        tick();
        idle();
        chk("post_sweep_a", bus.rd_data_a, 32'd0);
        chk("post_sweep_b", bus.rd_data_b, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
